dmem_responder: RTL

//  Multi-cycle data-memory target serving the CPU's load/store port (request/response handshake).

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/load_align.sv | 27 ++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I size codes,
// FSM state encoding and the store byte-lane enable function.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] lane_enable(input logic [1:0] addr_lo,
                                               input logic [2:0] funct3);
        logic [3:0] lanes;
        case (funct3)
            F3_B:    lanes = 4'b0001 << addr_lo;
            F3_H:    lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a RAM word and applies
// sign or zero extension according to the RV32I load size code.
module load_align (
    input  logic [31:0] rdata_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);
    import dmem_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_W:    value = rdata_word;
            F3_BU:   value = {24'h0, byte_sel};
            F3_HU:   value = {16'h0, half_sel};
            default: value = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target for the core's load/store port: one request
// at a time, fixed latency, byte-lane stores and fault reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    import dmem_pkg::*;

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [2:0]  cur_f3;
    logic        legal, misalign, out_of_range, fault;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word, load_value, wdata_rep;
    logic [3:0]  lanes;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    // While idle the live request is the access under evaluation (needed when
    // LATENCY==1 goes straight to RESP); afterwards the latched copy is.
    always_comb begin
        cur_wr   = (state_q == IDLE) ? req_wr     : wr_q;
        cur_addr = (state_q == IDLE) ? req_addr   : addr_q;
        cur_f3   = (state_q == IDLE) ? req_funct3 : f3_q;
        word_idx = cur_addr[AW+1:2];
    end

    always_comb begin
        case (cur_f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !cur_wr;
            default:          legal = 1'b0;
        endcase
        misalign     = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                       ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        out_of_range = cur_addr[31:2] >= 30'(DEPTH_WORDS);
        fault        = !legal || misalign || out_of_range;
    end

    assign rd_word = mem[word_idx];

    load_align u_load_align (
        .rdata_word (rd_word),
        .addr_lo    (cur_addr[1:0]),
        .funct3     (cur_f3),
        .value      (load_value)
    );

    always_comb begin
        case (f3_q[1:0])
            2'b00:   wdata_rep = {4{wdata_q[7:0]}};
            2'b01:   wdata_rep = {2{wdata_q[15:0]}};
            default: wdata_rep = wdata_q;
        endcase
        lanes  = lane_enable(addr_q[1:0], f3_q);
        mem_we = (state_q == RESP) && wr_q && !fault;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && lanes[i]) begin
                mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            f3_q        <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The response is registered on the edge that enters RESP, so rsp_valid
    // is high for exactly the RESP cycle and the data fields zero elsewhere.
    always_comb begin
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        if ((state_q == IDLE) && req_valid) begin
            wr_d    = req_wr;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            f3_d    = req_funct3;
        end
        rsp_valid_d = (state_d == RESP) && (state_q != RESP);
        rsp_err_d   = rsp_valid_d && fault;
        rsp_rdata_d = (rsp_valid_d && !fault && !cur_wr) ? load_value : 32'h0;
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
